// File: rtl/bsg_fsb_to_manycore_tunnel_rx.sv
// Receive end of the FSB channel tunnel: demuxes tagged packets into per-channel
// FIFOs and returns consumed-slot credits to the sender as FSB credit packets.
module bsg_fsb_to_manycore_tunnel_rx #(
    parameter int ring_width_p   = 80,
    parameter int dest_id_p      = 0,
    parameter int num_in_p       = 4,
    parameter int width_p        = 64,
    parameter int buffer_els_p   = 4,
    parameter int credit_batch_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             fsb_v_i,
    input  logic [ring_width_p-1:0]          fsb_data_i,
    output logic                             fsb_ready_o,
    output logic                             fsb_v_o,
    output logic [ring_width_p-1:0]          fsb_data_o,
    input  logic                             fsb_yumi_i,
    output logic [num_in_p-1:0]              chan_v_o,
    output logic [num_in_p-1:0][width_p-1:0] chan_data_o,
    input  logic [num_in_p-1:0]              chan_yumi_i,
    output logic                             err_o
);
    localparam int tag_w = $clog2(num_in_p + 1);
    localparam int cnt_w = $clog2(buffer_els_p + 1);
    localparam int ptr_w = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                            state_r;
    logic                              in_v_r;
    logic [tag_w-1:0]                  in_tag_r;
    logic [width_p-1:0]                in_data_r;
    logic [width_p-1:0]                mem_r [num_in_p][buffer_els_p];
    logic [num_in_p-1:0][ptr_w-1:0]    rd_ptr_r, wr_ptr_r;
    logic [num_in_p-1:0][cnt_w-1:0]    count_r, pending_r, pending_nxt;
    logic [num_in_p-1:0]               enq, deq, full_drop, bad_yumi;
    logic                              bad_tag, credit_due, take;
    logic [ring_width_p-1:0]           credit_pkt;
    logic                              unused_hdr;

    // Header bits above the tag carry nothing on the inbound side.
    assign unused_hdr = ^fsb_data_i[ring_width_p-1:width_p+tag_w];

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(buffer_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        enq        = '0;
        deq        = '0;
        full_drop  = '0;
        bad_yumi   = '0;
        credit_due = 1'b0;
        bad_tag    = in_v_r && (in_tag_r >= tag_w'(num_in_p));
        take       = (state_r == IDLE);
        for (int c = 0; c < num_in_p; c++) begin
            deq[c]      = chan_yumi_i[c] && chan_v_o[c];
            bad_yumi[c] = chan_yumi_i[c] && !chan_v_o[c];
            // A full FIFO still accepts when its head leaves in the same cycle.
            enq[c]       = in_v_r && (in_tag_r == tag_w'(c))
                           && ((count_r[c] != cnt_w'(buffer_els_p)) || deq[c]);
            full_drop[c] = in_v_r && (in_tag_r == tag_w'(c)) && !enq[c];
            if (pending_r[c] >= cnt_w'(credit_batch_p)) credit_due = 1'b1;
        end
        take = take && credit_due;
        for (int c = 0; c < num_in_p; c++) begin
            if (take)
                pending_nxt[c] = cnt_w'(deq[c]);
            else if (deq[c] && (pending_r[c] != cnt_w'(buffer_els_p)))
                pending_nxt[c] = pending_r[c] + 1'b1;
            else
                pending_nxt[c] = pending_r[c];
        end
    end

    always_comb begin
        credit_pkt = '0;
        credit_pkt[ring_width_p-1 -: 4] = 4'(dest_id_p);
        credit_pkt[width_p +: tag_w]    = tag_w'(num_in_p);
        for (int c = 0; c < num_in_p; c++)
            credit_pkt[c*cnt_w +: cnt_w] = pending_r[c];
    end

    // NOTE: every clocked process uses <= so all registers sample pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsb_ready_o <= 1'b0;
            in_v_r      <= 1'b0;
            in_tag_r    <= '0;
            in_data_r   <= '0;
            err_o       <= 1'b0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            pending_r   <= '0;
        end else begin
            fsb_ready_o <= 1'b1;
            in_v_r      <= fsb_v_i && fsb_ready_o;
            if (fsb_v_i && fsb_ready_o) begin
                in_tag_r  <= fsb_data_i[width_p +: tag_w];
                in_data_r <= fsb_data_i[width_p-1:0];
            end
            err_o     <= err_o || bad_tag || (|full_drop) || (|bad_yumi);
            pending_r <= pending_nxt;
            for (int c = 0; c < num_in_p; c++) begin
                if (enq[c]) wr_ptr_r[c] <= next_ptr(wr_ptr_r[c]);
                if (deq[c]) rd_ptr_r[c] <= next_ptr(rd_ptr_r[c]);
                count_r[c] <= count_r[c] + cnt_w'(enq[c]) - cnt_w'(deq[c]);
            end
        end
    end

    // NOTE: storage is not reset; count_r alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_in_p; c++)
            if (enq[c]) mem_r[c][wr_ptr_r[c]] <= in_data_r;
    end

    always_comb begin
        for (int c = 0; c < num_in_p; c++) begin
            chan_v_o[c]    = (count_r[c] != '0);
            chan_data_o[c] = mem_r[c][rd_ptr_r[c]];
        end
    end

    // Snapshot of all pending counts is taken on IDLE->SEND and held until consumed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            fsb_v_o    <= 1'b0;
            fsb_data_o <= '0;
        end else begin
            case (state_r)
                IDLE: if (credit_due) begin
                    state_r    <= SEND;
                    fsb_v_o    <= 1'b1;
                    fsb_data_o <= credit_pkt;
                end
                SEND: if (fsb_yumi_i) begin
                    state_r <= IDLE;
                    fsb_v_o <= 1'b0;
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_fsb_to_manycore_tunnel_rx.sv
// Self-checking bench for bsg_fsb_to_manycore_tunnel_rx: directed scenarios plus
// credit-respecting random traffic checked against a queue-based channel model.
module tb_bsg_fsb_to_manycore_tunnel_rx;
    localparam int RW = 80, W = 64, NUM = 4, BUF = 4, TAG_W = 3, CNT_W = 3;
    localparam int DEST1 = 5, DEST2 = 9;

    logic clk = 1'b0, rst_n = 1'b0;
    int   cyc = 0, n_checks = 0, n_fail = 0;

    logic                     fsb_v_i = 0, fsb_ready_o, fsb_v_o, fsb_yumi_i = 0, err_o;
    logic [RW-1:0]            fsb_data_i = '0, fsb_data_o;
    logic [NUM-1:0]           chan_v_o, chan_yumi_i = '0;
    logic [NUM-1:0][W-1:0]    chan_data_o;

    logic                     b_fsb_v_i = 0, b_fsb_ready_o, b_fsb_v_o, b_fsb_yumi_i = 0, b_err_o;
    logic [RW-1:0]            b_fsb_data_i = '0, b_fsb_data_o;
    logic [NUM-1:0]           b_chan_v_o, b_chan_yumi_i = '0;
    logic [NUM-1:0][W-1:0]    b_chan_data_o;

    bsg_fsb_to_manycore_tunnel_rx #(.ring_width_p(RW), .dest_id_p(DEST1), .num_in_p(NUM),
        .width_p(W), .buffer_els_p(BUF), .credit_batch_p(1)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i),
        .fsb_ready_o(fsb_ready_o), .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o),
        .fsb_yumi_i(fsb_yumi_i), .chan_v_o(chan_v_o), .chan_data_o(chan_data_o),
        .chan_yumi_i(chan_yumi_i), .err_o(err_o));

    bsg_fsb_to_manycore_tunnel_rx #(.ring_width_p(RW), .dest_id_p(DEST2), .num_in_p(NUM),
        .width_p(W), .buffer_els_p(BUF), .credit_batch_p(2)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .fsb_v_i(b_fsb_v_i), .fsb_data_i(b_fsb_data_i),
        .fsb_ready_o(b_fsb_ready_o), .fsb_v_o(b_fsb_v_o), .fsb_data_o(b_fsb_data_o),
        .fsb_yumi_i(b_fsb_yumi_i), .chan_v_o(b_chan_v_o), .chan_data_o(b_chan_data_o),
        .chan_yumi_i(b_chan_yumi_i), .err_o(b_err_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Inbound packet with random junk in every ignored header bit.
    function automatic logic [RW-1:0] mk_pkt(input int tag, input logic [W-1:0] pl);
        logic [RW-1:0] p;
        p = RW'({$urandom(), $urandom(), $urandom()});
        p[W +: TAG_W] = TAG_W'(tag);
        p[W-1:0] = pl;
        return p;
    endfunction

    // Credit packet as the sender expects to see it.
    function automatic logic [RW-1:0] exp_pkt(input int dest, input int cnt [NUM]);
        logic [RW-1:0] p;
        p = '0;
        p[RW-1 -: 4] = 4'(dest);
        p[W +: TAG_W] = TAG_W'(NUM);
        for (int c = 0; c < NUM; c++) p[c*CNT_W +: CNT_W] = CNT_W'(cnt[c]);
        return p;
    endfunction

    function automatic int get_cnt(input logic [RW-1:0] p, input int c);
        return int'(p[c*CNT_W +: CNT_W]);
    endfunction

    task automatic do_reset();
        fsb_v_i = 0; fsb_data_i = '0; fsb_yumi_i = 0; chan_yumi_i = '0;
        b_fsb_v_i = 0; b_fsb_data_i = '0; b_fsb_yumi_i = 0; b_chan_yumi_i = '0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        logic [RW-1:0] junk;
        junk = mk_pkt(1, rand64());
        rst_n = 0; fsb_v_i = 1; fsb_data_i = junk;
        tick(); tick(); tick();
        n_checks++; if ({fsb_ready_o, fsb_v_o, chan_v_o, err_o} !== 7'b0)
            begin n_fail++; $display("FAIL reset_hold: ready/v/chan_v/err=%b expected 0", {fsb_ready_o, fsb_v_o, chan_v_o, err_o}); end
        n_checks++; if (fsb_data_o !== '0)
            begin n_fail++; $display("FAIL reset_data: got %h expected 0", fsb_data_o); end
        fsb_v_i = 0; rst_n = 1;
        n_checks++; if (fsb_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_release_ready0: got %b expected 0", fsb_ready_o); end
        tick();
        n_checks++; if (fsb_ready_o !== 1'b1 || fsb_v_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_release: ready=%b v=%b expected 1/0", fsb_ready_o, fsb_v_o); end
        // mid-stream: data queued, a credit packet outstanding, inbound still valid
        fsb_v_i = 1; fsb_data_i = mk_pkt(1, rand64()); tick();
        fsb_data_i = mk_pkt(1, rand64()); tick();
        fsb_data_i = mk_pkt(0, rand64()); chan_yumi_i = 4'b0010; tick();
        chan_yumi_i = '0; tick(); tick();
        #2 rst_n = 0;
        #1;
        n_checks++; if ({fsb_ready_o, fsb_v_o, chan_v_o, err_o} !== 7'b0)
            begin n_fail++; $display("FAIL reset_async: ready/v/chan_v/err=%b expected 0", {fsb_ready_o, fsb_v_o, chan_v_o, err_o}); end
        n_checks++; if (fsb_data_o !== '0)
            begin n_fail++; $display("FAIL reset_async_data: got %h expected 0", fsb_data_o); end
        tick();
        fsb_v_i = 0; rst_n = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (fsb_v_o !== 1'b0 || chan_v_o !== '0 || fsb_ready_o !== 1'b1)
                begin n_fail++; $display("FAIL reset_after[%0d]: v=%b chan_v=%b ready=%b expected 0/0/1", i, fsb_v_o, chan_v_o, fsb_ready_o); end
            tick();
        end
    endtask

    task automatic test_routing();
        do_reset();
        fsb_v_i = 1; fsb_data_i = mk_pkt(2, 64'hDEAD_BEEF);
        tick();
        fsb_v_i = 0;
        n_checks++; if (chan_v_o !== 4'b0000)
            begin n_fail++; $display("FAIL route_t1: chan_v=%b expected 0000", chan_v_o); end
        tick();
        n_checks++; if (chan_v_o !== 4'b0100)
            begin n_fail++; $display("FAIL route_t2: chan_v=%b expected 0100", chan_v_o); end
        n_checks++; if (chan_data_o[2] !== 64'hDEAD_BEEF)
            begin n_fail++; $display("FAIL route_data: got %h expected deadbeef", chan_data_o[2]); end
    endtask

    task automatic test_credit();
        int cnt [NUM] = '{0, 1, 0, 0};
        logic [RW-1:0] exp;
        int wait_cyc = 0;
        do_reset();
        exp = exp_pkt(DEST1, cnt);
        fsb_v_i = 1; fsb_data_i = mk_pkt(1, rand64()); tick();
        fsb_v_i = 0; tick();
        chan_yumi_i = 4'b0010; tick();
        chan_yumi_i = '0;
        while (fsb_v_o !== 1'b1 && wait_cyc < 6) begin tick(); wait_cyc++; end
        n_checks++; if (fsb_v_o !== 1'b1)
            begin n_fail++; $display("FAIL credit_timeout: no credit packet within %0d cycles", wait_cyc); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (fsb_v_o !== 1'b1 || fsb_data_o !== exp)
                begin n_fail++; $display("FAIL credit_hold[%0d]: v=%b data=%h expected 1/%h", i, fsb_v_o, fsb_data_o, exp); end
            tick();
        end
        fsb_yumi_i = 1; tick();
        fsb_yumi_i = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fsb_v_o !== 1'b0)
                begin n_fail++; $display("FAIL credit_done[%0d]: v=%b expected 0", i, fsb_v_o); end
            tick();
        end
    endtask

    task automatic test_errors();
        logic [W-1:0] pl [5];
        do_reset();
        fsb_v_i = 1; fsb_data_i = mk_pkt(NUM, rand64()); tick();
        fsb_v_i = 0; tick();
        n_checks++; if (err_o !== 1'b1 || chan_v_o !== '0)
            begin n_fail++; $display("FAIL err_badtag: err=%b chan_v=%b expected 1/0000", err_o, chan_v_o); end
        for (int i = 0; i < 5; i++) begin
            pl[i] = rand64();
            fsb_v_i = 1; fsb_data_i = mk_pkt(3, pl[i]); tick();
        end
        fsb_v_i = 0; tick(); tick(); tick();
        n_checks++; if (chan_v_o !== 4'b1000 || err_o !== 1'b1)
            begin n_fail++; $display("FAIL err_full: chan_v=%b err=%b expected 1000/1", chan_v_o, err_o); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (chan_v_o[3] !== 1'b1 || chan_data_o[3] !== pl[i])
                begin n_fail++; $display("FAIL err_fifo3[%0d]: v=%b data=%h expected 1/%h", i, chan_v_o[3], chan_data_o[3], pl[i]); end
            chan_yumi_i = 4'b1000; tick();
        end
        chan_yumi_i = '0;
        n_checks++; if (chan_v_o[3] !== 1'b0 || err_o !== 1'b1)
            begin n_fail++; $display("FAIL err_dropped: chan_v3=%b err=%b expected 0/1", chan_v_o[3], err_o); end
        do_reset();
        n_checks++; if (err_o !== 1'b0)
            begin n_fail++; $display("FAIL err_cleared: err=%b expected 0", err_o); end
        chan_yumi_i = 4'b0001; tick();
        chan_yumi_i = '0;
        n_checks++; if (err_o !== 1'b1)
            begin n_fail++; $display("FAIL err_yumi: err=%b expected 1", err_o); end
        tick(); tick(); tick();
        n_checks++; if (fsb_v_o !== 1'b0)
            begin n_fail++; $display("FAIL err_yumi_credit: v=%b expected 0", fsb_v_o); end
    endtask

    task automatic test_concurrent_credits();
        logic [W-1:0] pl [4];
        int exp_cnt [NUM] = '{2, 0, 0, 0};
        int npk = 0, tot = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pl[i] = rand64();
            b_fsb_v_i = 1; b_fsb_data_i = mk_pkt(0, pl[i]); tick();
        end
        b_fsb_v_i = 0; tick(); tick();
        n_checks++; if (b_chan_v_o !== 4'b0001 || b_fsb_v_o !== 1'b0)
            begin n_fail++; $display("FAIL batch_fill: chan_v=%b v=%b expected 0001/0", b_chan_v_o, b_fsb_v_o); end
        for (int k = 0; k < 16; k++) begin
            b_fsb_yumi_i = 0;
            if (b_fsb_v_o === 1'b1) begin
                n_checks++; if (b_fsb_data_o !== exp_pkt(DEST2, exp_cnt))
                    begin n_fail++; $display("FAIL batch_pkt[%0d]: got %h expected %h", npk, b_fsb_data_o, exp_pkt(DEST2, exp_cnt)); end
                npk++; tot += get_cnt(b_fsb_data_o, 0);
                b_fsb_yumi_i = 1;
            end
            b_chan_yumi_i = '0;
            if (k < 4) begin
                n_checks++; if (b_chan_v_o[0] !== 1'b1 || b_chan_data_o[0] !== pl[k])
                    begin n_fail++; $display("FAIL batch_data[%0d]: v=%b data=%h expected 1/%h", k, b_chan_v_o[0], b_chan_data_o[0], pl[k]); end
                b_chan_yumi_i = 4'b0001;
            end
            tick();
        end
        b_fsb_yumi_i = 0; b_chan_yumi_i = '0;
        n_checks++; if (npk != 2 || tot != 4)
            begin n_fail++; $display("FAIL batch_totals: packets=%0d credits=%0d expected 2/4", npk, tot); end
        n_checks++; if (b_chan_v_o !== '0 || b_err_o !== 1'b0)
            begin n_fail++; $display("FAIL batch_end: chan_v=%b err=%b expected 0/0", b_chan_v_o, b_err_o); end
    endtask

    // Credit-respecting sender and random consumers against per-channel queues.
    task automatic run_traffic(input string name, input int n, input bit rr,
                               input int yumi_pct, input int send_pct);
        logic [W-1:0] q_pl [NUM][$];
        int q_vis [NUM][$];
        int credits [NUM], deq_cnt [NUM], ret [NUM], cnt [NUM];
        bit exp_v [NUM];
        int sent = 0, ret_sum = 0, budget = 0, next_tag = 0, tag, sum;
        logic [W-1:0] pl;
        do_reset();
        for (int c = 0; c < NUM; c++) begin credits[c] = BUF; deq_cnt[c] = 0; ret[c] = 0; end
        while (ret_sum < n && budget < 3000) begin
            for (int c = 0; c < NUM; c++) begin
                exp_v[c] = (q_pl[c].size() > 0) && (q_vis[c][0] <= cyc);
                n_checks++; if (chan_v_o[c] !== exp_v[c])
                    begin n_fail++; $display("FAIL %s chan_v[%0d] cyc %0d: got %b expected %b", name, c, cyc, chan_v_o[c], exp_v[c]); end
                if (exp_v[c]) begin
                    n_checks++; if (chan_data_o[c] !== q_pl[c][0])
                        begin n_fail++; $display("FAIL %s data[%0d] cyc %0d: got %h expected %h", name, c, cyc, chan_data_o[c], q_pl[c][0]); end
                end
            end
            n_checks++; if (err_o !== 1'b0)
                begin n_fail++; $display("FAIL %s err cyc %0d: got %b expected 0", name, cyc, err_o); end
            fsb_yumi_i = 0;
            if (fsb_v_o === 1'b1) begin
                sum = 0;
                for (int c = 0; c < NUM; c++) begin cnt[c] = get_cnt(fsb_data_o, c); sum += cnt[c]; end
                n_checks++; if (fsb_data_o !== exp_pkt(DEST1, cnt) || sum == 0)
                    begin n_fail++; $display("FAIL %s credit_fmt cyc %0d: got %h sum %0d", name, cyc, fsb_data_o, sum); end
                if ($urandom_range(99) < yumi_pct) begin
                    fsb_yumi_i = 1;
                    for (int c = 0; c < NUM; c++) begin
                        ret[c] += cnt[c]; credits[c] += cnt[c]; ret_sum += cnt[c];
                        n_checks++; if (ret[c] > deq_cnt[c])
                            begin n_fail++; $display("FAIL %s over_credit[%0d]: returned %0d dequeued %0d", name, c, ret[c], deq_cnt[c]); end
                    end
                end
            end
            for (int c = 0; c < NUM; c++) begin
                chan_yumi_i[c] = 1'b0;
                if (exp_v[c] && $urandom_range(99) < yumi_pct) begin
                    chan_yumi_i[c] = 1'b1;
                    void'(q_pl[c].pop_front()); void'(q_vis[c].pop_front());
                    deq_cnt[c]++;
                end
            end
            fsb_v_i = 0;
            if (sent < n && $urandom_range(99) < send_pct) begin
                tag = rr ? next_tag : int'($urandom_range(NUM - 1));
                if (credits[tag] > 0) begin
                    pl = rand64();
                    fsb_v_i = 1; fsb_data_i = mk_pkt(tag, pl);
                    q_pl[tag].push_back(pl); q_vis[tag].push_back(cyc + 2);
                    credits[tag]--; sent++;
                    if (rr) next_tag = (next_tag + 1) % NUM;
                end
            end
            tick();
            budget++;
        end
        fsb_v_i = 0; fsb_yumi_i = 0; chan_yumi_i = '0;
        n_checks++; if (budget >= 3000)
            begin n_fail++; $display("FAIL %s timeout: sent %0d credited %0d of %0d", name, sent, ret_sum, n); end
        n_checks++; if (sent != n || ret_sum != n)
            begin n_fail++; $display("FAIL %s totals: sent %0d credited %0d expected %0d", name, sent, ret_sum, n); end
        n_checks++; if (err_o !== 1'b0 || chan_v_o !== '0)
            begin n_fail++; $display("FAIL %s end: err=%b chan_v=%b expected 0/0000", name, err_o, chan_v_o); end
    endtask

    task automatic test_back_to_back();
        run_traffic("back_to_back", 100, 1'b1, 100, 100);
    endtask

    task automatic test_random();
        run_traffic("random", 200, 1'b0, 60, 70);
    endtask

    initial begin
        test_reset();
        test_routing();
        test_credit();
        test_errors();
        test_concurrent_credits();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bsg_fsb_to_manycore_tunnel_rx.md
Name: bsg_fsb_to_manycore_tunnel_rx

Overview:
- Receive-side endpoint of the FSB channel-tunnel link: accepts tagged FSB client packets, demultiplexes them by tag into `num_in_p` per-channel buffers, and presents each channel as a valid/yumi stream toward manycore-link adapters.
- Counts packets consumed per channel and returns credits to the sending tunnel as FSB credit packets (tag == `num_in_p`), so the sender never overruns a channel buffer.

Parameters:
- `ring_width_p`, 80: FSB packet width.
- `dest_id_p`, 0: 4-bit FSB destid placed on outbound credit packets.
- `num_in_p`, 4: number of tunneled channels.
- `width_p`, 64: channel payload width.
- `buffer_els_p`, 4: per-channel FIFO depth; equals the sender's initial credit count per channel.
- `credit_batch_p`, 1: pending-credit threshold that triggers a credit packet; legal range 1..`buffer_els_p`.

Ports:
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: reset, asynchronous active-low.
- `fsb_v_i`, in, 1: inbound FSB packet valid.
- `fsb_data_i`, in, `ring_width_p`: inbound FSB packet.
- `fsb_ready_o`, out, 1: inbound ready (valid/ready).
- `fsb_v_o`, out, 1: outbound credit packet valid.
- `fsb_data_o`, out, `ring_width_p`: outbound credit packet.
- `fsb_yumi_i`, in, 1: outbound consumed (valid/yumi).
- `chan_v_o`, out, `num_in_p`: per-channel data valid.
- `chan_data_o`, out, `num_in_p` x `width_p`: per-channel payload.
- `chan_yumi_i`, in, `num_in_p`: per-channel dequeue.
- `err_o`, out, 1: sticky protocol-error flag.

Behaviour:
- Widths:
  - `tag_w = clog2(num_in_p+1)`.
  - `cnt_w = clog2(buffer_els_p+1)`.
  - Legal only when `tag_w + width_p <= ring_width_p - 5` and `num_in_p * cnt_w <= width_p`.
- Inbound format:
  - Payload is `fsb_data_i[width_p-1:0]`.
  - Tag is `fsb_data_i[width_p +: tag_w]`.
  - All other bits are ignored.
- Reset (async assert, sync deassert, by the integrator):
  - All FIFOs empty; pending counters 0; FSM in IDLE.
  - `fsb_ready_o = 0`, `fsb_v_o = 0`, `chan_v_o = 0`, `err_o = 0`.
  - `fsb_data_o = 0`.
  - Reset mid-transfer discards everything with no partial credit packet.
- Input stage:
  - One-entry input register; `fsb_ready_o = 1` whenever out of reset.
  - The register drains into the target FIFO on the cycle after capture, so latency from `fsb_v_i` to `chan_v_o` is 2 cycles, with sustained throughput of 1 packet/cycle.
- Routing:
  - Tag < `num_in_p`: enqueue into FIFO[tag].
  - Tag >= `num_in_p`: drop the packet and set `err_o`.
  - Enqueue into a full FIFO (sender violated credits): drop, set `err_o`, FIFO contents unchanged.
- Channel outputs:
  - `chan_v_o[c]` is high iff FIFO[c] is non-empty; `chan_data_o[c]` is the head entry.
  - `chan_yumi_i[c]` is legal only while `chan_v_o[c]` is high; an illegal yumi is ignored and sets `err_o`.
  - Enqueue and dequeue on the same FIFO in the same cycle is legal, including when full (dequeue frees the slot first).
- Pending credits:
  - `pending[c]` (`cnt_w` bits) increments on each legal `chan_yumi_i[c]`.
  - It can never exceed `buffer_els_p`.
- Credit FSM:
  - IDLE → SEND when any `pending[c] >= credit_batch_p`.
  - On that transition, `snap[c] = pending[c]` for all c.
  - `pending[c]` next value = `pending[c] - snap[c] + yumi[c]`, so increments arriving in the same cycle are kept.
  - In SEND, `fsb_v_o = 1` and `fsb_data_o` is held stable.
  - SEND → IDLE on `fsb_yumi_i`. Next-cycle re-entry to SEND is allowed, giving at most 1 credit packet per 2 cycles.
- Credit packet (`fsb_data_o`):
  - `[ring_width_p-1 -: 4] = dest_id_p`.
  - Next bit: cmd = 0.
  - Tag field: `num_in_p`.
  - Payload: `snap[c]` at bits `[c*cnt_w +: cnt_w]`.
  - All other bits 0.
- Deadlock freedom: follows from `credit_batch_p <= buffer_els_p`.

Test Plan:
- Reset: hold `reset_n_i = 0` mid-stream with `fsb_v_i = 1` → all outputs 0 asynchronously. Release → `fsb_ready_o = 1` next cycle, no credit packet.
- Routing: send tag 2 with payload `0xDEAD_BEEF` at cycle t → `chan_v_o[2] = 1` at t+2 with `chan_data_o[2] = 0xDEADBEEF`; other channels stay idle.
- Credits (batch 1): dequeue channel 1 once → one credit packet: destid = `dest_id_p`, tag = 4, `count[1] = 1`, other counts 0. Stall `fsb_yumi_i` 5 cycles → data held stable.
- Concurrent credits (batch 2, depth 4): fill channel 0 with 4 packets, dequeue one per cycle → credit packet with count 2, then `pending[0]` continues 1..2 and a second packet with count 2 follows. Totals match dequeues (4).
- Errors: send tag 4, then a fifth packet to full channel 3 → both dropped, FIFO 3 still holds 4 entries, `err_o = 1` sticky until reset.
- Full throughput: 100 back-to-back packets round-robin across 4 channels, consumers always yumi → no drops, `err_o = 0`, returned credits sum to 100.
